// File: rtl/phold_pkg.sv
// phold_pkg: shared types, widths and PRNG field positions for the PHOLD LP engine.
package phold_pkg;
    localparam int NUM_LP  = 8;
    localparam int TIME_W  = 13;
    localparam int LP_ID_W = $clog2(NUM_LP);
    localparam int GVT_W   = 14;
    localparam int OUT_W   = 16;
    localparam int RND_W   = 8;
    localparam int INC_MSB = 7;
    localparam int INC_LSB = 3;
    localparam int TGT_MSB = 2;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {IDLE, PROCESS, SEND} state_t;

    // Increment is 1..32, added at output width so 8191 + 32 does not wrap.
    function automatic logic [OUT_W-1:0] next_time(input logic [TIME_W-1:0] t,
                                                   input logic [RND_W-1:0] r);
        return OUT_W'(t) + OUT_W'(r[INC_MSB:INC_LSB]) + OUT_W'(1);
    endfunction
endpackage

// File: rtl/phold_lvt_table.sv
// phold_lvt_table: per-LP local virtual time registers, one write port, one async read port, async clear.
module phold_lvt_table
    import phold_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [LP_ID_W-1:0] waddr,
    input  logic [TIME_W-1:0]  wdata,
    input  logic [LP_ID_W-1:0] raddr,
    output logic [TIME_W-1:0]  rdata
);
    logic [TIME_W-1:0] lvt [NUM_LP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LP; i++) lvt[i] <= '0;
        end else if (we) begin
            lvt[waddr] <= wdata;
        end
    end

    assign rdata = lvt[raddr];
endmodule

// File: rtl/phold_lp_engine.sv
// phold_lp_engine: accepts a dispatched event, waits PROC_DELAY cycles, emits one future event, tracks LVT causality.
// Optional PHOLD_LP_STATS_EN adds events_processed and causality_cnt counters.
module phold_lp_engine
    import phold_pkg::*;
#(
    parameter int PROC_DELAY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               event_valid,
    input  logic [LP_ID_W-1:0] event_id,
    input  logic [TIME_W-1:0]  event_time,
    input  logic [GVT_W-1:0]   global_time,
    input  logic [RND_W-1:0]   random_in,
    input  logic               ack,
    output logic               ready,
    output logic               new_event_ready,
    output logic [OUT_W-1:0]   new_event_time,
    output logic [LP_ID_W-1:0] new_event_target,
    output logic               causality_err
`ifdef PHOLD_LP_STATS_EN
    ,
    output logic [15:0]        events_processed,
    output logic [7:0]         causality_cnt
`endif
);
    state_t             state, state_nx;
    logic [3:0]         cnt;
    logic [TIME_W-1:0]  ev_time;
    logic [RND_W-1:0]   rnd;
    logic [TIME_W-1:0]  lvt_rd;
    logic               accept, violation, done, unused_gvt_msb;

    assign ready           = state == IDLE;
    assign new_event_ready = state == SEND;
    assign accept          = ready && event_valid;
    assign done            = state == PROCESS && cnt == '0;
    assign violation       = event_time < lvt_rd || event_time < global_time[TIME_W-1:0];
    assign unused_gvt_msb  = ^global_time[GVT_W-1:TIME_W];

    phold_lvt_table u_lvt (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (event_id),
        .wdata (event_time),
        .raddr (event_id),
        .rdata (lvt_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = event_valid ? PROCESS : IDLE;
            PROCESS: state_nx = cnt == '0 ? SEND : PROCESS;
            SEND:    state_nx = ack ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            ev_time          <= '0;
            rnd              <= '0;
            new_event_time   <= '0;
            new_event_target <= '0;
            causality_err    <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(PROC_DELAY - 1);
                ev_time <= event_time;
                rnd     <= random_in;
                if (violation) causality_err <= 1'b1;
            end else if (state == PROCESS && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                new_event_time   <= next_time(ev_time, rnd);
                new_event_target <= rnd[TGT_MSB:TGT_LSB];
            end
        end
    end

`ifdef PHOLD_LP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_processed <= '0;
            causality_cnt    <= '0;
        end else begin
            if (new_event_ready && ack) events_processed <= events_processed + 16'd1;
            if (accept && violation && causality_cnt != 8'hFF) causality_cnt <= causality_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_phold_lp_engine.sv
// tb_phold_lp_engine: randomized self-checking bench with a behavioural LVT/timestamp model.
module tb_phold_lp_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        event_valid = 1'b0;
    logic [2:0]  event_id = '0;
    logic [12:0] event_time = '0;
    logic [13:0] global_time = '0;
    logic [7:0]  random_in = '0;
    logic        ack = 1'b0;
    logic        ready, new_event_ready, causality_err;
    logic [15:0] new_event_time;
    logic [2:0]  new_event_target;

    int total = 0;
    int bad = 0;

    int          m_lvt [8];
    logic        m_err;

    phold_lp_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .event_valid      (event_valid),
        .event_id         (event_id),
        .event_time       (event_time),
        .global_time      (global_time),
        .random_in        (random_in),
        .ack              (ack),
        .ready            (ready),
        .new_event_ready  (new_event_ready),
        .new_event_time   (new_event_time),
        .new_event_target (new_event_target),
        .causality_err    (causality_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_accept(input int id, input int t, input int r, input int g);
        if (t < m_lvt[id] || t < (g % 8192)) m_err = 1'b1;
        m_lvt[id] = t;
        return t + (r / 8) + 1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        event_valid = 1'b0;
        ack = 1'b0;
        global_time = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_lvt[i] = 0;
        m_err = 1'b0;
    endtask

    // Drives one accept and waits for new_event_ready; returns latency in cycles and ready seen after accept.
    task automatic accept_event(input int id, input int t, input int r, input int g,
                                output int lat, output logic rdy_after, output int exp_time);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL accept_wait: ready=%0b required 1", ready);
        end
        event_valid = 1'b1;
        event_id = 3'(id);
        event_time = 13'(t);
        random_in = 8'(r);
        global_time = 14'(g);
        exp_time = model_accept(id, t, r, g);
        @(negedge clk);
        event_valid = 1'b0;
        random_in = 8'($urandom);
        rdy_after = ready;
        lat = 1;
        while (!new_event_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({ready, new_event_ready, new_event_time, new_event_target, causality_err} !== {1'b1, 1'b0, 16'd0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: rdy=%0b ner=%0b time=%0d tgt=%0d err=%0b required 1 0 0 0 0",
                     ready, new_event_ready, new_event_time, new_event_target, causality_err);
        end
    endtask

    task automatic test_basic();
        int lat, et; logic ra;
        accept_event(5, 100, 'h2B, 0, lat, ra, et);
        total++;
        if (ra !== 1'b0) begin bad++; $display("FAIL basic_ready_low: got %0b required 0", ra); end
        total++;
        if (lat != 5) begin bad++; $display("FAIL basic_latency: got %0d required 5", lat); end
        total++;
        if (new_event_time !== 16'(et) || et != 106) begin
            bad++; $display("FAIL basic_time: got %0d required %0d", new_event_time, et);
        end
        total++;
        if (new_event_target !== 3'd3) begin bad++; $display("FAIL basic_target: got %0d required 3", new_event_target); end
        pulse_ack();
        total++;
        if (ready !== 1'b1 || new_event_ready !== 1'b0) begin
            bad++; $display("FAIL basic_handshake: rdy=%0b ner=%0b required 1 0", ready, new_event_ready);
        end
    endtask

    task automatic test_stall();
        int lat, et; logic ra; logic stable = 1'b1;
        accept_event(5, 100, 'h2B, 0, lat, ra, et);
        repeat (10) begin
            @(negedge clk);
            if (new_event_ready !== 1'b1 || ready !== 1'b0 || new_event_time !== 16'(et) || new_event_target !== 3'd3)
                stable = 1'b0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL stall_stable: outputs changed while ack low, required time=%0d tgt=3", et); end
        pulse_ack();
        total++;
        if (ready !== 1'b1 || new_event_ready !== 1'b0) begin
            bad++; $display("FAIL stall_release: rdy=%0b ner=%0b required 1 0", ready, new_event_ready);
        end
    endtask

    task automatic test_ignore();
        int lat, et, extra = 0; logic ra;
        @(negedge clk);
        event_valid = 1'b1; event_id = 3'd7; event_time = 13'd500; random_in = 8'h08;
        et = model_accept(7, 500, 'h08, 0);
        @(negedge clk);
        event_time = 13'd8000; ack = 1'b1;
        @(negedge clk);
        event_valid = 1'b0; ack = 1'b0;
        lat = 0;
        while (!new_event_ready && lat < 100) begin @(negedge clk); lat++; end
        event_valid = 1'b1; event_time = 13'd8000;
        repeat (2) @(negedge clk);
        event_valid = 1'b0;
        total++;
        if (new_event_ready !== 1'b1 || new_event_time !== 16'(et)) begin
            bad++; $display("FAIL ignore_send: ner=%0b time=%0d required 1 %0d", new_event_ready, new_event_time, et);
        end
        pulse_ack();
        repeat (8) begin
            @(negedge clk);
            if (new_event_ready) extra++;
        end
        total++;
        if (extra != 0 || ready !== 1'b1) begin
            bad++; $display("FAIL ignore_no_second: extra=%0d rdy=%0b required 0 1", extra, ready);
        end
        accept_event(7, 600, 0, 0, lat, ra, et);
        total++;
        if (causality_err !== m_err || m_err !== 1'b0) begin
            bad++; $display("FAIL ignore_lvt: err=%0b required %0b", causality_err, m_err);
        end
        pulse_ack();
    endtask

    task automatic test_causality();
        int lat, et; logic ra;
        accept_event(2, 50, 0, 0, lat, ra, et); pulse_ack();
        total++;
        if (causality_err !== 1'b0) begin bad++; $display("FAIL caus_legal: got %0b required 0", causality_err); end
        accept_event(2, 50, 0, 0, lat, ra, et); pulse_ack();
        total++;
        if (causality_err !== 1'b0) begin bad++; $display("FAIL caus_equal: got %0b required 0", causality_err); end
        accept_event(2, 40, 0, 0, lat, ra, et); pulse_ack();
        total++;
        if (causality_err !== 1'b1) begin bad++; $display("FAIL caus_lvt: got %0b required 1", causality_err); end
        accept_event(3, 1000, 0, 0, lat, ra, et); pulse_ack();
        total++;
        if (causality_err !== 1'b1) begin bad++; $display("FAIL caus_sticky: got %0b required 1", causality_err); end
        apply_reset();
        accept_event(4, 55, 0, 60, lat, ra, et); pulse_ack();
        total++;
        if (causality_err !== 1'b1) begin bad++; $display("FAIL caus_gvt: got %0b required 1", causality_err); end
    endtask

    task automatic test_random();
        int lat, et, id, t, r, g, w; logic ra;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            id = int'($urandom_range(0, 7));
            t = int'($urandom_range(0, 8191));
            r = int'($urandom_range(0, 255));
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : 0;
            accept_event(id, t, r, g, lat, ra, et);
            total++;
            if (lat != 5 || new_event_time !== 16'(et) || new_event_target !== 3'(r % 8) || causality_err !== m_err) begin
                bad++;
                $display("FAIL rand_%0d: lat=%0d time=%0d tgt=%0d err=%0b required 5 %0d %0d %0b",
                         k, lat, new_event_time, new_event_target, causality_err, et, r % 8, m_err);
            end
            w = int'($urandom_range(0, 3));
            repeat (w) @(negedge clk);
            pulse_ack();
        end
    endtask

    task automatic test_max_and_reset();
        int lat, et; logic ra;
        apply_reset();
        accept_event(1, 8191, 'hFF, 0, lat, ra, et);
        total++;
        if (new_event_time !== 16'h201F || et != 8223 || new_event_target !== 3'd7) begin
            bad++; $display("FAIL max_time: time=%0d tgt=%0d required 8223 7", new_event_time, new_event_target);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (new_event_ready !== 1'b0 || ready !== 1'b1 || new_event_time !== 16'd0) begin
            bad++; $display("FAIL async_reset: ner=%0b rdy=%0b time=%0d required 0 1 0", new_event_ready, ready, new_event_time);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_lvt[i] = 0;
        m_err = 1'b0;
        accept_event(1, 0, 0, 0, lat, ra, et);
        total++;
        if (causality_err !== 1'b0) begin bad++; $display("FAIL reset_lvt_clear: err=%0b required 0", causality_err); end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_causality();
        test_random();
        test_max_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phold_lp_engine.md
Name: phold_lp_engine

Overview:
- Downstream consumer of the PHOLD event dispatcher; four instances sit behind the send/receive round-robin arbiters.
- Accepts one dispatched event (LP id, timestamp) and models a fixed processing latency.
- Generates exactly one new future event (timestamp, target LP) from the shared PRNG byte, then holds it until the receive arbiter grants it.
- Keeps a per-LP local-virtual-time table and flags causality violations.

Parameters:
- NUM_LP, 8, number of logical processes; the LP id is $clog2(NUM_LP) bits wide (3 at default).
- TIME_W, 13, event timestamp width.
- PROC_DELAY, 4, cycles spent in PROCESS; legal range is 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- event_valid  in  1  dispatched event strobe; qualified by ready
- event_id  in  3  target LP of the dispatched event
- event_time  in  TIME_W  timestamp of the dispatched event
- global_time  in  14  current GVT; used for the lookback check only
- random_in  in  8  PRNG byte; sampled on the accept cycle
- ack  in  1  receive-arbiter grant for this engine
- ready  out  1  engine idle and able to accept an event
- new_event_ready  out  1  new event is held on the outputs
- new_event_time  out  16  new event timestamp, zero-extended
- new_event_target  out  3  LP the new event is addressed to
- causality_err  out  1  sticky causality-violation flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, ready = 1, new_event_ready = 0
  - new_event_time = 0, new_event_target = 0, causality_err = 0
  - every lvt entry = 0, delay counter = 0
- State IDLE:
  - ready = 1.
  - event_valid = 1 accepts the event: latch event_id and event_time, sample random_in, go to PROCESS, load the counter with PROC_DELAY-1.
  - Accept-to-ready-low latency is 1 cycle. The next earliest accept is PROC_DELAY+2 cycles later.
- State PROCESS:
  - ready = 0.
  - Counter decrements each cycle; at 0, go to SEND.
  - On the PROCESS→SEND edge:
    - new_event_time = zero-extended event_time + (random_in[7:3] + 1). The increment range is 1..32, computed at full width with no wrap; the maximum is 8191 + 32 = 8223.
    - new_event_target = random_in[2:0].
- State SEND:
  - new_event_ready = 1; outputs held stable.
  - Transfer occurs on a cycle with ack = 1. The next cycle gives new_event_ready = 0, ready = 1, state = IDLE.
  - ack held low stalls indefinitely with outputs stable.
- Handshake rules:
  - event_valid while ready = 0 is ignored; no latch, no state change.
  - ack while new_event_ready = 0 is ignored.
  - ack asserted on the first SEND cycle completes in one cycle.
- LVT and causality check (on the accept cycle):
  - If event_time < lvt[event_id], or event_time < global_time[TIME_W-1:0], set causality_err.
  - causality_err stays set until reset.
  - lvt[event_id] is updated to event_time unconditionally; the comparison uses the pre-update value.
  - Equal timestamps are legal.
- Reset mid-operation: any state returns to IDLE immediately and asynchronously. A pending new event is discarded, and the lvt table is cleared.
- random_in changing after the accept cycle has no effect.

Optional Feature:
- Macro: PHOLD_LP_STATS_EN.
- When defined:
  - Adds output events_processed[15:0]: increments on each SEND handshake, wraps 0xFFFF→0, and resets to 0.
  - Adds output causality_cnt[7:0]: increments on each violating accept and saturates at 0xFF.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package phold_pkg holds:
  - state enum (IDLE, PROCESS, SEND)
  - TIME_W, NUM_LP, LP_ID_W
  - increment field slice positions within random_in
- One natural sub-module: phold_lvt_table. It holds NUM_LP x TIME_W registers with one write port, one read port, and an async clear.

Test Plan:
- Reset release with idle inputs → ready = 1, new_event_ready = 0, all outputs 0, causality_err = 0.
- Accept event_id = 5, event_time = 100, random_in = 0x2B, PROC_DELAY = 4:
  - ready low on the next cycle.
  - new_event_ready rises 5 cycles after accept, with new_event_time = 106 and new_event_target = 3.
- Same event with ack held low for 10 cycles, then pulsed:
  - outputs are stable throughout.
  - handshake completes and ready = 1 one cycle after the ack.
- event_valid pulsed during PROCESS and SEND → ignored; lvt unchanged; no second new event.
- Accept id = 2 at time 50, then id = 2 at time 40 → causality_err = 1 and stays 1 through later legal events. Repeat with global_time = 60 and event_time = 55 → also flagged.
- event_time = 8191 with random_in = 0xFF → new_event_time = 8223 (16'h201F). Assert rst_n low mid-SEND → immediate IDLE with new_event_ready = 0.
